// File: rtl/dsp_be_patt_filt_ctrl.sv
// Pattern-filter bring-up/run sequencer: lane reset/enable sequencing,
// cfg_eq shadow handshake and pipeline-fill tracking for flag validity.
module dsp_be_patt_filt_ctrl #(
    parameter int PRLL_RANK          = 64,
    parameter int PRE_PIPELINE_DEPTH = 3,
    parameter int PST_PIPELINE_DEPTH = 2,
    parameter int RST_HOLD_CYC       = 4,
    parameter int SYNC_DEPTH         = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [PRLL_RANK-1:0] i_lane_mask,
    input  logic [7:0]           i_cfg_eq_en,
    input  logic                 i_cfg_upd_req,
    output logic                 o_cfg_upd_ack,
    output logic [PRLL_RANK-1:0] o_pf_rst,
    output logic [PRLL_RANK-1:0] o_pf_en,
    output logic [7:0]           o_cfg_eq_en,
    output logic                 o_flag_vld,
    output logic                 o_busy,
    output logic [2:0]           o_state
);

    localparam int FILL_CYC = PRE_PIPELINE_DEPTH + PST_PIPELINE_DEPTH + 1;
    localparam int MAX_AB   = (RST_HOLD_CYC > SYNC_DEPTH) ? RST_HOLD_CYC : SYNC_DEPTH;
    localparam int MAX_CYC  = (MAX_AB > FILL_CYC) ? MAX_AB : FILL_CYC;
    localparam int CW       = $clog2(MAX_CYC) + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST      = 3'd1;
    localparam logic [2:0] S_WAKE     = 3'd2;
    localparam logic [2:0] S_FILL     = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_CFG_FILL = 3'd5;

    localparam logic [CW-1:0] RST_LD  = CW'(RST_HOLD_CYC - 1);
    localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_DEPTH - 1);
    localparam logic [CW-1:0] FILL_LD = CW'(FILL_CYC - 1);
    localparam logic [CW-1:0] PST_LD  = CW'(PST_PIPELINE_DEPTH - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [PRLL_RANK-1:0] mask_q;
    logic [PRLL_RANK-1:0] mask_nxt;
    logic [PRLL_RANK-1:0] rst_nxt;
    logic [PRLL_RANK-1:0] en_nxt;
    logic                 req_q;
    logic                 load;
    logic                 cnt_zero;
    logic                 live;
    logic                 on;

    // req_q remembers the level seen last cycle, so only a rising req loads
    assign load     = i_cfg_upd_req && !req_q;
    assign cnt_zero = (cnt == '0);
    assign o_state  = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = mask_q;
        case (state)
            S_IDLE: begin
                if (i_start && (|i_lane_mask)) begin
                    mask_nxt  = i_lane_mask;
                    cnt_nxt   = RST_LD;
                    state_nxt = S_RST;
                end
            end
            S_RST: begin
                if (cnt_zero) begin
                    cnt_nxt   = SYNC_LD;
                    state_nxt = S_WAKE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_WAKE: begin
                if (cnt_zero) begin
                    cnt_nxt   = FILL_LD;
                    state_nxt = S_FILL;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_FILL: begin
                if (load) begin
                    cnt_nxt = FILL_LD;
                end else if (cnt_zero) begin
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_RUN: begin
                if (load) begin
                    cnt_nxt   = PST_LD;
                    state_nxt = S_CFG_FILL;
                end
            end
            S_CFG_FILL: begin
                if (load) begin
                    cnt_nxt = PST_LD;
                end else if (cnt_zero) begin
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (i_stop) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    // outputs are decoded from the next state so they flop with it
    always_comb begin
        live    = 1'b0;
        on      = 1'b0;
        unique case (1'b1)
            (state_nxt == S_WAKE): live = 1'b1;
            (state_nxt == S_FILL),
            (state_nxt == S_RUN),
            (state_nxt == S_CFG_FILL): begin
                live = 1'b1;
                on   = 1'b1;
            end
            default: ;
        endcase
        rst_nxt = live ? ~mask_nxt : '1;
        en_nxt  = on ? mask_nxt : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            mask_q        <= '0;
            req_q         <= 1'b0;
            o_cfg_upd_ack <= 1'b0;
            o_cfg_eq_en   <= '0;
            o_pf_rst      <= '1;
            o_pf_en       <= '0;
            o_flag_vld    <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            mask_q        <= mask_nxt;
            req_q         <= i_cfg_upd_req;
            o_cfg_upd_ack <= load;
            if (load) begin
                o_cfg_eq_en <= i_cfg_eq_en;
            end
            o_pf_rst      <= rst_nxt;
            o_pf_en       <= en_nxt;
            o_flag_vld    <= (state_nxt == S_RUN);
            o_busy        <= (state_nxt != S_IDLE) && (state_nxt != S_RUN);
        end
    end

endmodule
